// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_bus_responder
// Brief   : CPU data-bus slave decoding word RAM, an MMIO page (LED, timer,
//           status, scratch) and unmapped addresses; 1-cycle registered reads.
// Revision: 1.0 - initial release
// ============================================================================
module data_bus_responder #(
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h1FD0_F000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dbus_addr,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_byteenable,
    output logic [31:0] dbus_data,
    output logic [15:0] led_out,
    output logic        timer_irq,
    output logic        bus_error
);

    localparam int          c_AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0] c_RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    localparam logic [5:0] c_OFF_LED     = 6'd0;
    localparam logic [5:0] c_OFF_COUNT   = 6'd1;
    localparam logic [5:0] c_OFF_COMPARE = 6'd2;
    localparam logic [5:0] c_OFF_STATUS  = 6'd3;
    localparam logic [5:0] c_OFF_SCRATCH = 6'd4;

    logic [31:0] mem [RAM_WORDS];

    logic [31:0] dbus_data_q, dbus_data_d;
    logic [15:0] led_q,       led_d;
    logic [31:0] count_q,     count_d;
    logic [31:0] compare_q,   compare_d;
    logic        status_q,    status_d;
    logic [31:0] scratch_q,   scratch_d;
    logic        bus_err_q,   bus_err_d;

    logic            w_ram_hit;
    logic            w_mmio_hit;
    logic            w_unmapped;
    logic [5:0]      w_off;
    logic [c_AW-1:0] w_ram_idx;
    logic            w_wr_ram;
    logic            w_wr_mmio;
    logic [31:0]     w_rdata;
    logic            w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Word index inside the MMIO page; byte offset bits [1:0] are don't-care.
    assign w_off      = dbus_addr[7:2];
    assign w_ram_idx  = dbus_addr[c_AW+1:2];
    assign w_ram_hit  = ({1'b0, dbus_addr} < c_RAM_BYTES);
    assign w_mmio_hit = !w_ram_hit && (dbus_addr[31:8] == MMIO_BASE[31:8])
                        && (w_off <= c_OFF_SCRATCH);
    assign w_unmapped = (dbus_read || dbus_write) && !w_ram_hit && !w_mmio_hit;
    assign w_wr_ram   = dbus_write && w_ram_hit && !reset;
    assign w_wr_mmio  = dbus_write && w_mmio_hit;
    assign w_unused   = ^dbus_addr[1:0];

    always_comb begin
        w_rdata = 32'h0;
        if (w_ram_hit) begin
            w_rdata = mem[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_off)
                c_OFF_LED:     w_rdata = {16'h0, led_q};
                c_OFF_COUNT:   w_rdata = count_q;
                c_OFF_COMPARE: w_rdata = compare_q;
                c_OFF_STATUS:  w_rdata = {31'h0, status_q};
                c_OFF_SCRATCH: w_rdata = scratch_q;
                default:       w_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        dbus_data_d = dbus_read ? w_rdata : dbus_data_q;
        led_d       = led_q;
        count_d     = count_q + 32'd1;
        compare_d   = compare_q;
        status_d    = status_q;
        scratch_d   = scratch_q;
        bus_err_d   = bus_err_q | w_unmapped;

        if (w_wr_mmio) begin
            case (w_off)
                c_OFF_LED: begin
                    if (dbus_byteenable[0]) led_d[7:0]  = dbus_wdata[7:0];
                    if (dbus_byteenable[1]) led_d[15:8] = dbus_wdata[15:8];
                end
                c_OFF_COUNT:   count_d   = f_merge(count_q, dbus_wdata, dbus_byteenable);
                c_OFF_COMPARE: compare_d = f_merge(compare_q, dbus_wdata, dbus_byteenable);
                c_OFF_STATUS: begin
                    if (dbus_byteenable[0] && dbus_wdata[0]) status_d = 1'b0;
                end
                c_OFF_SCRATCH: scratch_d = f_merge(scratch_q, dbus_wdata, dbus_byteenable);
                default: ;
            endcase
        end

        // A compare match outranks a simultaneous software clear.
        if (count_q == compare_q) status_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dbus_data_q <= 32'h0;
            led_q       <= 16'h0;
            count_q     <= 32'h0;
            compare_q   <= 32'hFFFF_FFFF;
            status_q    <= 1'b0;
            scratch_q   <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            dbus_data_q <= dbus_data_d;
            led_q       <= led_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            scratch_q   <= scratch_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (dbus_byteenable[i]) mem[w_ram_idx][8*i +: 8] <= dbus_wdata[8*i +: 8];
            end
        end
    end

    assign dbus_data = dbus_data_q;
    assign led_out   = led_q;
    assign timer_irq = status_q;
    assign bus_error = bus_err_q;

endmodule
`default_nettype wire
